// File: rtl/brightness_frame_ctrl.sv
// Frame sequencer for the brightness/threshold processor: latches per-frame config,
// streams cfg_len words through the non-stalling processor into a small output FIFO.
// Optional BRIGHT_CTRL_ABORT_EN adds an abort input that flushes the frame.
`ifndef COLOR_SIZE
`define COLOR_SIZE 8
`endif

module brightness_frame_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [1:0]             cfg_mode,
  input  logic [`COLOR_SIZE-1:0] cfg_val,
  input  logic [LEN_WIDTH-1:0]   cfg_len,
`ifdef BRIGHT_CTRL_ABORT_EN
  input  logic                   abort,
`endif
  input  logic                   in_vld,
  output logic                   in_rdy,
  input  logic [DATA_WIDTH-1:0]  in_data,
  output logic                   proc_vld,
  output logic [1:0]             proc_mode,
  output logic [`COLOR_SIZE-1:0] proc_val,
  output logic [DATA_WIDTH-1:0]  proc_data,
  input  logic [DATA_WIDTH-1:0]  proc_dout,
  input  logic                   proc_dout_rdy,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   busy,
  output logic                   frame_done
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [LEN_WIDTH-1:0]                 len_q, issued;
  logic                                 inflight;
  logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] mem;
  logic [AW-1:0]                        wr_ptr, rd_ptr;
  logic [CW-1:0]                        count, count_nxt;
  logic [CW:0]                          occ;
  logic                                 start_ok, hs, push, pop, abort_hit;

`ifdef BRIGHT_CTRL_ABORT_EN
  assign abort_hit = abort && (state == RUN || state == DRAIN);
`else
  assign abort_hit = 1'b0;
`endif

  assign start_ok  = start && (state == IDLE);
  // Space is reserved for the word already inside the processor, since it cannot stall.
  assign occ       = {1'b0, count} + (CW+1)'(inflight);
  assign in_rdy    = (state == RUN) && (issued < len_q) &&
                     (occ < (CW+1)'(FIFO_DEPTH)) && !abort_hit;
  assign hs        = in_vld && in_rdy;
  assign proc_vld  = hs;
  assign proc_data = in_data;
  assign push      = proc_dout_rdy;
  assign out_vld   = (count != '0);
  assign pop       = out_vld && out_rdy;
  assign out_data  = mem[rd_ptr];
  assign count_nxt = count + CW'(push) - CW'(pop);

  always_comb begin
    state_nxt  = state;
    busy       = (state != IDLE);
    frame_done = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = (cfg_len == '0) ? DONE : RUN;
      RUN:   if (hs && ((issued + LEN_WIDTH'(1)) == len_q)) state_nxt = DRAIN;
      // Exit once the word leaving the FIFO this cycle is the last one.
      DRAIN: if (!inflight && count_nxt == '0) state_nxt = DONE;
      DONE: begin
        frame_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort_hit) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      len_q     <= '0;
      proc_mode <= '0;
      proc_val  <= '0;
      issued    <= '0;
      inflight  <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= hs;
      if (start_ok) begin
        len_q     <= cfg_len;
        proc_mode <= cfg_mode;
        proc_val  <= cfg_val;
      end
      if (start_ok || abort_hit) issued <= '0;
      else if (hs)               issued <= issued + LEN_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (abort_hit) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !abort_hit) mem[wr_ptr] <= proc_dout;
  end
endmodule

// File: tb/tb_brightness_frame_ctrl.sv
// Bench for brightness_frame_ctrl: a one-cycle processor stub plus a queue-based
// reference of expected output words; directed frames followed by random frames.
`ifndef COLOR_SIZE
`define COLOR_SIZE 8
`endif

module tb_brightness_frame_ctrl;
  localparam int DW = 32, FD = 4, LW = 16, CS = `COLOR_SIZE;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [1:0]    cfg_mode = '0;
  logic [CS-1:0] cfg_val = '0;
  logic [LW-1:0] cfg_len = '0;
  logic          abort = 1'b0;
  logic          in_vld = 1'b0, in_rdy, proc_vld, proc_dout_rdy, out_vld, out_rdy = 1'b0;
  logic          busy, frame_done;
  logic [DW-1:0] in_data = '0, proc_data, proc_dout, out_data;
  logic [1:0]    proc_mode;
  logic [CS-1:0] proc_val;

  brightness_frame_ctrl #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_mode(cfg_mode), .cfg_val(cfg_val),
    .cfg_len(cfg_len),
`ifdef BRIGHT_CTRL_ABORT_EN
    .abort(abort),
`endif
    .in_vld(in_vld), .in_rdy(in_rdy), .in_data(in_data), .proc_vld(proc_vld),
    .proc_mode(proc_mode), .proc_val(proc_val), .proc_data(proc_data),
    .proc_dout(proc_dout), .proc_dout_rdy(proc_dout_rdy), .out_vld(out_vld),
    .out_rdy(out_rdy), .out_data(out_data), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Processor stand-in: one-cycle result, word XORed with the replicated value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      proc_dout_rdy <= 1'b0;
      proc_dout     <= '0;
    end else begin
      proc_dout_rdy <= proc_vld;
      proc_dout     <= proc_data ^ {(DW/CS){proc_val}};
    end
  end

  int passed = 0, total = 0;
  logic [DW-1:0] exp_q[$];
  logic [CS-1:0] cur_val;
  logic [DW-1:0] fixed_data = '0;
  bit  use_fixed = 0, rdy_seen, ov_seen;
  int  occ = 0, cyc = 0, start_cyc, first_acc, first_out, last_pop, done_cyc;
  int  acc_cnt, pop_cnt, fd_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_stats();
    first_acc = -1; first_out = -1; last_pop = -1; done_cyc = -1;
    acc_cnt = 0; pop_cnt = 0; fd_cnt = 0; rdy_seen = 0; ov_seen = 0;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input bit ivld, input bit ordy);
    bit acc, pp;
    in_vld  = ivld;
    out_rdy = ordy;
    in_data = use_fixed ? fixed_data : DW'($urandom);
    #1;
    acc = in_vld && in_rdy;
    pp  = out_vld && out_rdy;
    chk("proc_vld", proc_vld, acc);
    if (acc) begin
      chk("proc_data", proc_data, in_data);
      exp_q.push_back(in_data ^ {(DW/CS){cur_val}});
      acc_cnt++;
      if (first_acc < 0) first_acc = cyc;
    end
    if (out_vld && first_out < 0) first_out = cyc;
    if (pp) begin
      if (exp_q.size() == 0) chk("spurious_out", 1, 0);
      else chk("out_data", out_data, exp_q.pop_front());
      pop_cnt++;
      last_pop = cyc;
    end
    if (proc_dout_rdy && !pp) chk("push_not_full", occ < FD, 1);
    occ += int'(proc_dout_rdy) - int'(pp);
    if (frame_done) begin fd_cnt++; done_cyc = cyc; end
    if (in_rdy)  rdy_seen = 1;
    if (out_vld) ov_seen = 1;
    cyc++;
    @(negedge clk);
  endtask

  task automatic kick(input logic [1:0] m, input logic [CS-1:0] v, input logic [LW-1:0] l);
    start = 1'b1; cfg_mode = m; cfg_val = v; cfg_len = l;
    start_cyc = cyc;
    step(0, 1);
    start = 1'b0;
  endtask

  task automatic finish_frame(input int budget, input int ivld_pct, input int ordy_pct,
                              input logic [CS-1:0] v);
    int n = 0;
    while (busy && n < budget) begin
      if (n % 8 == 0) chk("proc_val_held", proc_val, v);
      step(bit'($urandom_range(0, 99) < ivld_pct), bit'($urandom_range(0, 99) < ordy_pct));
      n++;
    end
    chk("frame_timeout", busy, 0);
  endtask

  initial begin
    #2;
    chk("rst_in_rdy", in_rdy, 0);
    chk("rst_proc_vld", proc_vld, 0);
    chk("rst_proc_mode", proc_mode, 0);
    chk("rst_proc_val", proc_val, 0);
    chk("rst_out_vld", out_vld, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    in_data = 32'hDEAD_BEEF;
    #1 chk("rst_proc_data", proc_data, 32'hDEAD_BEEF);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Basic frame with fixed word and latency/done timing.
    clear_stats(); use_fixed = 1; fixed_data = 32'h10F0_2030; cur_val = 8'h10;
    kick(2'd2, 8'h10, 16'd3);
    chk("busy_after_start", busy, 1);
    chk("in_rdy_after_start", in_rdy, 1);
    finish_frame(50, 100, 100, 8'h10);
    chk("f1_words", pop_cnt, 3);
    chk("f1_latency", first_out - first_acc, 2);
    chk("f1_done_after_pop", done_cyc - last_pop, 1);
    chk("f1_done_pulses", fd_cnt, 1);
    chk("f1_mode", proc_mode, 2);
    use_fixed = 0;

    // Backpressure: FIFO fills to depth, then drains in order.
    clear_stats(); cur_val = 8'hA7;
    kick(2'd1, 8'hA7, 16'd10);
    repeat (12) step(1, 0);
    chk("bp_accepted", acc_cnt, FD);
    chk("bp_in_rdy_low", in_rdy, 0);
    finish_frame(100, 100, 100, 8'hA7);
    chk("bp_words", pop_cnt, 10);
    chk("bp_queue_empty", exp_q.size(), 0);

    // Zero-length frame.
    clear_stats();
    kick(2'd0, 8'h01, 16'd0);
    finish_frame(10, 100, 100, 8'h01);
    chk("z_done_cycle", done_cyc - start_cyc, 1);
    chk("z_idle_cycle", cyc - start_cyc, 2);
    chk("z_in_rdy_never", rdy_seen, 0);
    chk("z_out_vld_never", ov_seen, 0);
    chk("z_done_pulses", fd_cnt, 1);

    // Start while busy is ignored.
    clear_stats(); cur_val = 8'h33;
    kick(2'd1, 8'h33, 16'd5);
    step(1, 1); step(1, 1);
    start = 1'b1; cfg_mode = 2'd3; cfg_val = 8'hFF; cfg_len = 16'd1;
    step(1, 1);
    start = 1'b0;
    chk("sb_val_kept", proc_val, 8'h33);
    chk("sb_mode_kept", proc_mode, 1);
    finish_frame(100, 100, 100, 8'h33);
    chk("sb_words", pop_cnt, 5);
    chk("sb_done_pulses", fd_cnt, 1);

    // Reset in RUN with two words held in the FIFO.
    clear_stats(); cur_val = 8'h5A;
    kick(2'd0, 8'h5A, 16'd8);
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    chk("mr_occ_before", occ, 2);
    in_vld = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mr_out_vld", out_vld, 0);
    chk("mr_busy", busy, 0);
    chk("mr_proc_vld", proc_vld, 0);
    chk("mr_in_rdy", in_rdy, 0);
    chk("mr_frame_done", frame_done, 0);
    exp_q.delete(); occ = 0; in_vld = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

`ifdef BRIGHT_CTRL_ABORT_EN
    // Abort in DRAIN with a full FIFO.
    clear_stats(); cur_val = 8'h0C;
    kick(2'd3, 8'h0C, 16'd4);
    repeat (5) step(1, 0);
    step(0, 0);
    chk("ab_busy_before", busy, 1);
    chk("ab_out_vld_before", out_vld, 1);
    abort = 1'b1;
    step(0, 0);
    abort = 1'b0;
    chk("ab_idle", busy, 0);
    chk("ab_out_vld", out_vld, 0);
    exp_q.delete(); occ = 0;
    step(0, 1); step(0, 1);
    chk("ab_no_done", fd_cnt, 0);
    chk("ab_still_empty", out_vld, 0);
`endif

    // Random frames with random handshake pressure.
    for (int f = 0; f < 5; f++) begin
      logic [1:0]    m;
      logic [CS-1:0] v;
      logic [LW-1:0] l;
      m = 2'($urandom_range(0, 3));
      v = CS'($urandom);
      l = LW'($urandom_range(1, 20));
      clear_stats(); cur_val = v;
      kick(m, v, l);
      finish_frame(600, 60, 55, v);
      chk("rnd_words", pop_cnt, 32'(l));
      chk("rnd_queue_empty", exp_q.size(), 0);
      chk("rnd_done_pulses", fd_cnt, 1);
      chk("rnd_mode", proc_mode, m);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/brightness_frame_ctrl.md
# brightness_frame_ctrl

Frame-level sequencer for the brightness/threshold pixel processor. It latches a per-frame configuration (mode, processing value, frame length in words) on a start pulse. It then streams exactly that many input words through the processor with valid/ready handshakes, and buffers the one-cycle processor results in a small output FIFO. The processor itself cannot stall, so the controller issues words only when FIFO space is guaranteed.

## Interface
- DATA_WIDTH, 32: pixel word width (32 or 64); multiple of `COLOR_SIZE`.
- FIFO_DEPTH, 4: output FIFO depth in words; power of two, ≥2.
- LEN_WIDTH, 16: width of frame length and word counters.

- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle frame start; sampled only in IDLE.
- cfg_mode  in  2  processor mode for the frame.
- cfg_val  in  `COLOR_SIZE`  threshold or brightness value for the frame.
- cfg_len  in  LEN_WIDTH  words in the frame.
- in_vld  in  1  input word valid.
- in_rdy  out  1  controller accepts input word.
- in_data  in  DATA_WIDTH  input pixel word.
- proc_vld  out  1  processor valid (drives processor vld).
- proc_mode  out  2  processor mode.
- proc_val  out  `COLOR_SIZE`  processor value.
- proc_data  out  DATA_WIDTH  processor data_in.
- proc_dout  in  DATA_WIDTH  processor data_out.
- proc_dout_rdy  in  1  processor data_out_rdy.
- out_vld  out  1  output word valid.
- out_rdy  in  1  downstream ready.
- out_data  out  DATA_WIDTH  output word (FIFO head).
- busy  out  1  high in any state except IDLE.
- frame_done  out  1  one-cycle pulse at frame end.

## Operation
- States:
  - IDLE → RUN on start (config latched).
  - IDLE → DONE on start with cfg_len==0.
  - RUN → DRAIN when issued count reaches len.
  - DRAIN → DONE when inflight==0 and FIFO empty.
  - DONE → IDLE unconditionally.
- proc_mode/proc_val are registered from cfg_* at start and held constant until the next accepted start. Reset value is 0.
- in_rdy = (state==RUN) && (issued<len) && (fifo_count + inflight < FIFO_DEPTH). inflight = registered proc_vld.
- proc_vld = in_vld && in_rdy (combinational). proc_data = in_data.
- Each handshake increments the issued counter. The counter clears on start.
- FIFO push occurs when proc_dout_rdy=1, pushing proc_dout. Pop occurs when out_vld && out_rdy. Simultaneous push and pop is legal: count unchanged, including when the FIFO is full.
- out_vld = FIFO non-empty. Word order is preserved.
- Push into a full FIFO cannot occur by construction. The bench asserts this.
- start while busy is ignored. The latched config is unchanged.
- frame_done asserts for exactly one cycle, in DONE.

## Timing
- Reset values: in_rdy=0, proc_vld=0, proc_mode=0, proc_val=0, proc_data follows in_data, out_vld=0, busy=0, frame_done=0. FIFO is empty, counters are 0, state is IDLE.
- start at cycle T → busy=1 and in_rdy may be 1 at T+1.
- Input accepted at cycle T → processor result pushed at edge T+1 → out_vld=1 at T+2 (FIFO was empty). Latency is 2 cycles.
- Throughput is 1 word/cycle with out_rdy held high.
- Last word accepted at T with out_rdy=1 → DRAIN at T+1 → popped at T+2 → DONE (frame_done=1) at T+3 → IDLE at T+4.
- cfg_len==0: start at T → frame_done=1 at T+1 → IDLE at T+2.
- Reset asserted mid-frame: all state returns immediately to reset values. FIFO contents and counters are discarded. No frame_done pulse.

## Configuration
- BRIGHT_CTRL_ABORT_EN
  - Defined: adds input port abort (1 bit). An abort pulse in RUN or DRAIN moves the controller to IDLE next cycle. in_rdy drops that cycle. The FIFO is flushed, the inflight result is discarded, counters clear, and frame_done is not pulsed. Abort in IDLE or DONE has no effect. Abort takes priority over start in the same cycle.
  - Undefined: port absent. A frame ends only by completion or reset.

## Test plan
- Single frame, cfg_mode=2, cfg_val=8'h10, cfg_len=3, word 32'h10F0_2030, out_rdy=1 → outputs in order, first output 2 cycles after accept, proc_val=8'h10 held throughout, frame_done one cycle after the last pop.
- Backpressure: FIFO_DEPTH=4, cfg_len=10, out_rdy=0 → exactly 4 words accepted then in_rdy=0. Release out_rdy → all 10 words delivered in order with no loss or duplicate.
- Zero length: start with cfg_len=0 → frame_done at T+1, in_rdy never 1, out_vld never 1.
- Start while busy: second start with cfg_val=8'hFF mid-frame → ignored, proc_val unchanged, frame completes with original length.
- Reset mid-frame: rst_n low during RUN with 2 words in FIFO → out_vld=0, busy=0, proc_vld=0 immediately. A new frame after reset runs cleanly.
- With BRIGHT_CTRL_ABORT_EN: abort in DRAIN with FIFO non-empty → next cycle IDLE, out_vld=0, no frame_done.
